peripheral_bus_hub: RTL

Parametrised successor to the fixed chipset I/O decoder. It decodes N I/O slots and asserts one active-low chip select per slot. It inserts per-slot programmable wait states and honours a per-slot ready handshake, then returns registered read data with a from-chipset flag. It sits between the CPU bus interface and the peripheral instances (8259/8253/8255/DMA/page and future slots).

---
 rtl/peripheral_bus_pkg.sv | 15 +
 rtl/peripheral_wait_counter.sv | 18 +
 rtl/peripheral_bus_hub.sv | 123 ++++++++++++
 3 files changed

// File: rtl/peripheral_bus_pkg.sv
// peripheral_bus_pkg: shared FSM states, slot map and helpers for the peripheral bus hub.
package peripheral_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} bus_state_e;
  typedef enum logic [3:0] {
    SLOT_DMA      = 4'd0,
    SLOT_PIC      = 4'd1,
    SLOT_PIT      = 4'd2,
    SLOT_PPI      = 4'd3,
    SLOT_DMA_PAGE = 4'd4
  } slot_id_e;
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;
  function automatic int slot_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/peripheral_wait_counter.sv
// peripheral_wait_counter: loadable down-counter with zero detect; saturates at zero.
module peripheral_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_val_i : (dec_i && count_q != '0) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  assign zero_o = (count_q == '0);
endmodule

// File: rtl/peripheral_bus_hub.sv
// peripheral_bus_hub: I/O slot decoder with per-slot wait states, ready handshake and read latch.
// Optional ready-stall timeout is built when BUS_TIMEOUT_EN is defined.
module peripheral_bus_hub
  import peripheral_bus_pkg::*;
#(
  parameter int SLOT_COUNT     = 8,
  parameter int SLOT_SEL_LO    = 5,
  parameter int IO_SPACE_BITS  = 10,
  parameter int WAIT_WIDTH     = 4,
  parameter int INTA_SLOT      = int'(SLOT_PIC),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             address_enable_n,
  input  logic [19:0]                      address,
  input  logic                             io_read_n,
  input  logic                             io_write_n,
  input  logic                             interrupt_acknowledge_n,
  input  logic [SLOT_COUNT*WAIT_WIDTH-1:0] slot_wait_states,
  input  logic [SLOT_COUNT-1:0]            slot_ready,
  input  logic [SLOT_COUNT*8-1:0]          slot_data_in,
  output logic [SLOT_COUNT-1:0]            chip_select_n,
  output logic                             io_ready,
  output logic [7:0]                       data_bus_out,
  output logic                             data_bus_out_from_chipset,
  output logic                             timeout_flag
);
  localparam int SW = slot_idx_width(SLOT_COUNT);
  localparam int HI = SLOT_SEL_LO + SW;
  logic [WAIT_WIDTH-1:0] waits [SLOT_COUNT];
  logic [7:0] datas [SLOT_COUNT];
  for (genvar g = 0; g < SLOT_COUNT; g++) begin : g_unpack
    assign waits[g] = slot_wait_states[g*WAIT_WIDTH +: WAIT_WIDTH];
    assign datas[g] = slot_data_in[g*8 +: 8];
  end
  bus_state_e state_q;
  logic [SW-1:0] slot_q;
  logic rd_q, strobe_q, io_ready_q;
  logic [7:0] data_q;
  logic hit, strobe, start, wzero, inta, rd_out;
  logic [SW-1:0] slot;
  logic [WAIT_WIDTH-1:0] w_sel;
  assign hit = !address_enable_n && (address[IO_SPACE_BITS-1:HI] == '0);
  assign slot = address[SLOT_SEL_LO +: SW];
  assign w_sel = waits[slot];
  assign strobe = !address_enable_n && (!io_read_n || !io_write_n);
  assign start = strobe && !strobe_q && hit && state_q == IDLE;
  assign chip_select_n = hit ? ~(SLOT_COUNT'(1) << slot) : '1;
  peripheral_wait_counter #(.WIDTH(WAIT_WIDTH)) u_wait (
    .clock(clock), .reset_n(reset_n), .load_i(start),
    .load_val_i(w_sel == '0 ? '0 : w_sel - 1'b1),
    .dec_i(state_q == WAIT), .zero_o(wzero)
  );
`ifdef BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic tzero, tflag_q;
  // Counts only stalled cycles: wait count expired while the slot still holds ready low.
  peripheral_wait_counter #(.WIDTH(TW)) u_timeout (
    .clock(clock), .reset_n(reset_n), .load_i(start),
    .load_val_i(TW'(TIMEOUT_CYCLES - 1)),
    .dec_i(state_q == WAIT && strobe && wzero && !slot_ready[slot_q]), .zero_o(tzero)
  );
  assign timeout_flag = tflag_q;
  logic unused_ok;
  assign unused_ok = ^{address[19:IO_SPACE_BITS], address[SLOT_SEL_LO-1:0]};
`else
  assign timeout_flag = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{address[19:IO_SPACE_BITS], address[SLOT_SEL_LO-1:0], TIMEOUT_FILL, TIMEOUT_CYCLES[0]};
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      io_ready_q <= 1'b1;
      data_q     <= 8'h00;
      strobe_q   <= 1'b0;
      slot_q     <= '0;
      rd_q       <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tflag_q    <= 1'b0;
`endif
    end else begin
      strobe_q <= strobe;
      case (state_q)
        IDLE: if (start) begin
          slot_q <= slot;
          rd_q   <= !io_read_n;
          if (w_sel == '0 && slot_ready[slot]) begin
            state_q <= DONE;
            data_q  <= datas[slot];
          end else begin
            state_q    <= WAIT;
            io_ready_q <= 1'b0;
          end
        end
        WAIT: if (!strobe) begin
          state_q    <= IDLE;
          io_ready_q <= 1'b1;
        end else if (wzero && slot_ready[slot_q]) begin
          state_q    <= DONE;
          io_ready_q <= 1'b1;
          data_q     <= datas[slot_q];
        end
`ifdef BUS_TIMEOUT_EN
        else if (wzero && tzero) begin
          state_q    <= DONE;
          io_ready_q <= 1'b1;
          data_q     <= TIMEOUT_FILL;
          tflag_q    <= 1'b1;
        end
`endif
        DONE: if (!strobe) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  // Interrupt acknowledge bypasses the FSM entirely and forces the PIC slot onto the bus.
  assign inta = !interrupt_acknowledge_n;
  assign rd_out = state_q == DONE && rd_q;
  assign io_ready = io_ready_q || inta;
  assign data_bus_out_from_chipset = inta || rd_out;
  assign data_bus_out = inta ? datas[INTA_SLOT] : rd_out ? data_q : 8'h00;
endmodule
